// File: rtl/reset_sequencer.sv
// Reset sequencer: holds every downstream reset, releases the channels one at a
// time, then watches the running system with a watchdog and a software reset request.
module reset_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int STAGE_GAP   = 2,
  parameter int NUM_OUT     = 2,
  parameter int WDT_WIDTH   = 8,
  parameter int WDT_LIMIT   = 200
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wdt_en,
  input  logic                 wdt_kick,
  input  logic                 sw_rst_req,
  output logic [NUM_OUT-1:0]   rst_out,
  output logic                 busy,
  output logic [1:0]           rst_cause,
  output logic [WDT_WIDTH-1:0] wdt_count
);

  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int STAGE_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  localparam logic [HOLD_W-1:0]    HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STAGE_W-1:0]   STAGE_LAST = STAGE_W'(STAGE_GAP - 1);
  localparam logic [WDT_WIDTH-1:0] WDT_LAST   = WDT_WIDTH'(WDT_LIMIT - 1);
  localparam logic [NUM_OUT-1:0]   RST_FIRST  = ~NUM_OUT'(1);

  localparam logic [1:0] CAUSE_EXT = 2'b00;
  localparam logic [1:0] CAUSE_WDT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t               r_state;
  logic [HOLD_W-1:0]    r_hold_cnt;
  logic [STAGE_W-1:0]   r_stage_cnt;
  logic [NUM_OUT-1:0]   r_rst_out;
  logic                 r_busy;
  logic [1:0]           r_cause;
  logic [WDT_WIDTH-1:0] r_wdt_cnt;

  state_t               w_state_nxt;
  logic [HOLD_W-1:0]    w_hold_nxt;
  logic [STAGE_W-1:0]   w_stage_nxt;
  logic [NUM_OUT-1:0]   w_rst_nxt;
  logic [NUM_OUT-1:0]   w_rst_shift;
  logic [1:0]           w_cause_nxt;
  logic [WDT_WIDTH-1:0] w_wdt_nxt;
  logic                 w_timeout;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_stage_nxt = r_stage_cnt;
    w_rst_nxt   = r_rst_out;
    w_cause_nxt = r_cause;
    w_wdt_nxt   = r_wdt_cnt;
    w_rst_shift = r_rst_out << 1;
    w_timeout   = (r_state == ST_RUN) && !wdt_kick && wdt_en && (r_wdt_cnt == WDT_LAST);

    case (r_state)
      ST_ASSERT: begin
        w_rst_nxt = '1;
        w_wdt_nxt = '0;
        if (r_hold_cnt == HOLD_LAST) begin
          w_hold_nxt  = '0;
          w_stage_nxt = '0;
          w_rst_nxt   = RST_FIRST;
          w_state_nxt = (NUM_OUT == 1) ? ST_RUN : ST_RELEASE;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end

      ST_RELEASE: begin
        w_wdt_nxt = '0;
        if (r_stage_cnt == STAGE_LAST) begin
          // Channels release low-to-high by shifting zeros in from bit 0.
          w_stage_nxt = '0;
          w_rst_nxt   = w_rst_shift;
          if (w_rst_shift == '0) begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_stage_nxt = r_stage_cnt + 1'b1;
        end
      end

      ST_RUN: begin
        if (wdt_kick) begin
          w_wdt_nxt = '0;
        end else if (wdt_en && !w_timeout) begin
          w_wdt_nxt = r_wdt_cnt + 1'b1;
        end
        // Watchdog timeout outranks a simultaneous software request.
        if (w_timeout || sw_rst_req) begin
          w_state_nxt = ST_ASSERT;
          w_hold_nxt  = '0;
          w_stage_nxt = '0;
          w_rst_nxt   = '1;
          w_wdt_nxt   = '0;
          w_cause_nxt = w_timeout ? CAUSE_WDT : CAUSE_SW;
        end
      end

      default: begin
        w_state_nxt = ST_ASSERT;
        w_hold_nxt  = '0;
        w_stage_nxt = '0;
        w_rst_nxt   = '1;
        w_wdt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      r_state     <= ST_ASSERT;
      r_hold_cnt  <= '0;
      r_stage_cnt <= '0;
      r_rst_out   <= '1;
      r_busy      <= 1'b1;
      r_cause     <= CAUSE_EXT;
      r_wdt_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_stage_cnt <= w_stage_nxt;
      r_rst_out   <= w_rst_nxt;
      r_busy      <= (w_state_nxt != ST_RUN);
      r_cause     <= w_cause_nxt;
      r_wdt_cnt   <= w_wdt_nxt;
    end
  end

  assign rst_out   = r_rst_out;
  assign busy      = r_busy;
  assign rst_cause = r_cause;
  assign wdt_count = r_wdt_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a timeline model (cycles since the sequence began)
// is compared every cycle, plus directed scenarios pinned to literal values.
module tb_reset_sequencer;

  localparam int HOLD_CYCLES = 4;
  localparam int STAGE_GAP   = 2;
  localparam int NUM_OUT     = 3;
  localparam int WDT_WIDTH   = 8;
  localparam int WDT_LIMIT   = 10;
  localparam int RUN_T       = HOLD_CYCLES + (NUM_OUT - 1) * STAGE_GAP;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 wdt_en;
  logic                 wdt_kick;
  logic                 sw_rst_req;
  logic [NUM_OUT-1:0]   rst_out;
  logic                 busy;
  logic [1:0]           rst_cause;
  logic [WDT_WIDTH-1:0] wdt_count;

  int vectors    = 0;
  int miscompares = 0;

  reset_sequencer #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .STAGE_GAP  (STAGE_GAP),
    .NUM_OUT    (NUM_OUT),
    .WDT_WIDTH  (WDT_WIDTH),
    .WDT_LIMIT  (WDT_LIMIT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wdt_en    (wdt_en),
    .wdt_kick  (wdt_kick),
    .sw_rst_req(sw_rst_req),
    .rst_out   (rst_out),
    .busy      (busy),
    .rst_cause (rst_cause),
    .wdt_count (wdt_count)
  );

  always #5 clock = ~clock;

  // Model state: cycles elapsed since the sequence (re)started, cause, watchdog count.
  int m_t     = 0;
  int m_cause = 0;
  int m_wdt   = 0;
  bit m_valid = 1'b0;

  function automatic logic [31:0] model_rst(input int t);
    logic [31:0] v = '0;
    for (int k = 0; k < NUM_OUT; k++) v[k] = (t < HOLD_CYCLES + k * STAGE_GAP);
    return v;
  endfunction

  function automatic logic [31:0] model_busy(input int t);
    return (t < RUN_T) ? 32'd1 : 32'd0;
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m_t = 0; m_cause = 0; m_wdt = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_t >= RUN_T) begin
        if (wdt_kick) m_wdt = 0;
        else if (wdt_en && m_wdt == WDT_LIMIT - 1) begin
          m_t = 0; m_cause = 1; m_wdt = 0;
        end else if (wdt_en) m_wdt = m_wdt + 1;
        if (m_t >= RUN_T && sw_rst_req) begin
          m_t = 0; m_cause = 2; m_wdt = 0;
        end
      end else begin
        m_t   = m_t + 1;
        m_wdt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (m_valid) begin
      check("cyc_rst_out",   32'(rst_out),   model_rst(m_t));
      check("cyc_busy",      32'(busy),      model_busy(m_t));
      check("cyc_rst_cause", 32'(rst_cause), 32'(m_cause));
      check("cyc_wdt_count", 32'(wdt_count), 32'(m_wdt));
    end
  end

  // Pins both the DUT and the model to hand-computed values.
  task automatic pin(input string name, input logic [2:0] e_rst, input logic e_busy,
                     input logic [1:0] e_cause, input int e_wdt);
    check({name, "_rst"},     32'(rst_out),       32'(e_rst));
    check({name, "_busy"},    32'(busy),          32'(e_busy));
    check({name, "_cause"},   32'(rst_cause),     32'(e_cause));
    check({name, "_wdt"},     32'(wdt_count),     32'(e_wdt));
    check({name, "_m_rst"},   model_rst(m_t),     32'(e_rst));
    check({name, "_m_cause"}, 32'(m_cause),       32'(e_cause));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; wdt_en = 1'b0; wdt_kick = 1'b0; sw_rst_req = 1'b0;
    cyc(3);
    pin("reset_state", 3'b111, 1'b1, 2'b00, 0);

    // Power-up release timeline.
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      pin("powerup",
          (i <= 3) ? 3'b111 : (i <= 5) ? 3'b110 : (i <= 7) ? 3'b100 : 3'b000,
          (i < 8), 2'b00, 0);
    end

    // Watchdog timeout.
    wdt_en = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      cyc(1);
      pin("wdt_count_up", 3'b000, 1'b0, 2'b00, j);
    end
    cyc(1);
    pin("timeout", 3'b111, 1'b1, 2'b01, 0);
    wdt_en = 1'b0;
    cyc(8);
    pin("timeout_rerun", 3'b000, 1'b0, 2'b01, 0);

    // Kick at the limit wins over timeout.
    wdt_en = 1'b1;
    cyc(9);
    pin("pre_kick", 3'b000, 1'b0, 2'b01, 9);
    wdt_kick = 1'b1;
    cyc(1);
    pin("kick_at_limit", 3'b000, 1'b0, 2'b01, 0);
    wdt_kick = 1'b0; wdt_en = 1'b0;

    // Software reset, then a request during RELEASE that must be ignored.
    sw_rst_req = 1'b1;
    cyc(1);
    pin("sw_reset", 3'b111, 1'b1, 2'b10, 0);
    sw_rst_req = 1'b0;
    cyc(4);
    pin("sw_release", 3'b110, 1'b1, 2'b10, 0);
    sw_rst_req = 1'b1;
    cyc(1);
    pin("sw_ignored", 3'b110, 1'b1, 2'b10, 0);
    sw_rst_req = 1'b0;
    cyc(3);
    pin("sw_run", 3'b000, 1'b0, 2'b10, 0);

    // Timeout and software request together: watchdog wins.
    wdt_en = 1'b1;
    cyc(9);
    sw_rst_req = 1'b1;
    cyc(1);
    pin("priority", 3'b111, 1'b1, 2'b01, 0);
    sw_rst_req = 1'b0; wdt_en = 1'b0;

    // External reset in the middle of RELEASE restarts the sequence.
    cyc(4);
    pin("mid_release", 3'b110, 1'b1, 2'b01, 0);
    reset = 1'b0;
    cyc(1);
    pin("mid_reset", 3'b111, 1'b1, 2'b00, 0);
    reset = 1'b1;
    cyc(8);
    pin("restart_run", 3'b000, 1'b0, 2'b00, 0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 99) != 0);
      wdt_en     = ($urandom_range(0, 3) != 0);
      wdt_kick   = ($urandom_range(0, 15) == 0);
      sw_rst_req = ($urandom_range(0, 39) == 0);
      cyc(1);
    end
    reset = 1'b1; wdt_en = 1'b0; wdt_kick = 1'b0; sw_rst_req = 1'b0;
    cyc(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameters (name, default, meaning); each SHALL be honoured as given:
- HOLD_CYCLES, 4, cycles all reset outputs stay asserted after entering ASSERT (>=1)
- STAGE_GAP, 2, cycles between successive channel releases (>=1)
- NUM_OUT, 2, number of sequenced reset channels (1..8)
- WDT_WIDTH, 8, watchdog counter width
- WDT_LIMIT, 200, consecutive unkicked enabled cycles that cause a timeout (1..2^WDT_WIDTH-1)
REQ-002 Ports (name, direction, width, meaning); the block SHALL provide exactly these:
- clock, in, 1, single clock; all state updates on its rising edge
- reset, in, 1, synchronous, active-low reset
- wdt_en, in, 1, watchdog count enable
- wdt_kick, in, 1, watchdog restart pulse
- sw_rst_req, in, 1, software reset request
- rst_out, out, NUM_OUT, active-high reset to each downstream channel; bit k is released k-th
- busy, out, 1, high whenever state is not RUN
- rst_cause, out, 2, cause of last sequence: 00 external, 01 watchdog, 10 software
- wdt_count, out, WDT_WIDTH, current watchdog count

Function
REQ-003 The block SHALL be a three-state FSM: ASSERT, RELEASE, RUN; all outputs registered.
REQ-004 ASSERT: rst_out SHALL be all ones; the hold counter SHALL increment each cycle; on the cycle the count equals HOLD_CYCLES-1, the block SHALL leave ASSERT, so ASSERT lasts exactly HOLD_CYCLES cycles.
REQ-005 On leaving ASSERT, rst_out[0] SHALL go low on that same edge; with NUM_OUT=1 the next state SHALL be RUN, otherwise RELEASE.
REQ-006 RELEASE: rst_out[k] SHALL go low exactly k*STAGE_GAP cycles after rst_out[0]; bits never re-assert within RELEASE.
REQ-007 The block SHALL enter RUN on the same edge that rst_out[NUM_OUT-1] goes low.
REQ-008 busy SHALL be 1 in ASSERT and RELEASE and 0 in RUN, registered with the state.
REQ-009 Watchdog in RUN: wdt_kick=1 SHALL clear wdt_count to 0; else wdt_en=1 SHALL increment it; else it SHALL hold.
REQ-010 Timeout: when wdt_count equals WDT_LIMIT-1, wdt_en=1 and wdt_kick=0, the next edge SHALL enter ASSERT, set all rst_out, set rst_cause=01 and clear wdt_count; wdt_count SHALL never wrap.
REQ-011 sw_rst_req=1 in RUN SHALL enter ASSERT on the next edge with rst_cause=10 and all rst_out set; sw_rst_req SHALL be ignored in ASSERT and RELEASE.
REQ-012 Simultaneous timeout and sw_rst_req: watchdog SHALL win (rst_cause=01).
REQ-013 Simultaneous wdt_kick and would-be timeout: kick SHALL win; no timeout, wdt_count=0.
REQ-014 wdt_count SHALL be held at 0 in ASSERT and RELEASE; wdt_en and wdt_kick are ignored there.
REQ-015 rst_cause SHALL hold its value from one sequence until the next cause is recorded.

Reset
REQ-016 While reset=0 at a rising edge: state SHALL become ASSERT, hold and stage counters 0, rst_out all ones, busy=1, rst_cause=00, wdt_count=0.
REQ-017 reset=0 SHALL override every other input and SHALL restart the sequence from ASSERT when taken mid-RELEASE or mid-RUN.
REQ-018 The first edge with reset=1 SHALL count as the first ASSERT cycle.

Verification
REQ-019 Bench parameters SHALL be HOLD_CYCLES=4, STAGE_GAP=2, NUM_OUT=3, WDT_LIMIT=10, WDT_WIDTH=8; the bench SHALL cover these scenarios:
- Power-up: reset low 3 cycles then high -> rst_out=111 for 4 cycles, then 110, 2 cycles later 100, 2 cycles later 000 with busy=0, rst_cause=00.
- Timeout: RUN, wdt_en=1, no kick -> wdt_count 0..9, next edge rst_out=111, rst_cause=01, wdt_count=0, sequence repeats.
- Kick at limit: wdt_count=9, wdt_en=1, wdt_kick=1 -> stays RUN, wdt_count=0, rst_out=000.
- Software reset: RUN, one-cycle sw_rst_req -> next edge rst_out=111, rst_cause=10, busy=1; pulse during RELEASE -> ignored.
- Priority: wdt_count=9, wdt_en=1 and sw_rst_req=1 together -> rst_cause=01.
- Mid-release reset: reset low while rst_out=110 -> next edge rst_out=111, rst_cause=00, full sequence restarts.
